program_loader: RTL and testbench

//  Writer side of the 64x12 instruction memory that the CPU fetches from. Accepts a framed byte

---
 rtl/lab4_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 15 +
 rtl/loader_timeout.sv | 21 ++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lab4_pkg.sv
// Shared types for the instruction-memory program loader: FSM states, error codes, frame header.
package lab4_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_COUNT = 2'd1,
        ERR_BAD_CHK   = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } loader_err_t;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave  (input  in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
    modport master (output in_data, in_valid, input  in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts running cycles without a handshake, flags the TIMEOUT-th one.
module loader_timeout #(
    parameter int TIMEOUT = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) r_cnt <= '0;
        else if (i_run)       r_cnt <= r_cnt + CW'(1);
    end

    assign o_expired = i_run && !i_clear && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/program_loader.sv
// Framed byte stream -> instruction words written from address 0; holds the CPU while loading.
module program_loader
    import lab4_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter int         DATA_W    = 12,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC,
    parameter int         TIMEOUT   = 5000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    program_loader_if.slave   bus,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W:0]   o_words_loaded
);
    localparam int         NW      = ADDR_W + 1;
    localparam logic [8:0] MAX_N   = 9'(2 ** ADDR_W);
    localparam logic [7:0] HI_MASK = 8'((1 << (DATA_W - 8)) - 1);

    loader_state_t     r_state, w_state_next;
    loader_err_t       r_err, w_err_next;
    logic              w_err_we;
    logic [NW-1:0]     r_n, r_words_loaded;
    logic [7:0]        r_chk;
    logic [DATA_W-1:0] r_word;
    logic              w_hs, w_sync, w_run, w_last, w_expired;

    assign w_hs   = bus.in_valid && bus.in_ready;
    assign w_sync = w_hs && (bus.in_data == SYNC_BYTE);
    assign w_run  = (r_state == S_COUNT) || (r_state == S_HI) ||
                    (r_state == S_LO)    || (r_state == S_CHECK);
    assign w_last = (r_words_loaded + NW'(1)) == r_n;

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_hs || !w_run),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = ERR_NONE;
        w_err_we     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_sync) begin
                    w_state_next = S_COUNT;
                    w_err_we     = 1'b1;
                end
            end
            S_COUNT: begin
                if (w_expired) begin
                    w_state_next = S_ERROR; w_err_next = ERR_TIMEOUT; w_err_we = 1'b1;
                end else if (w_hs) begin
                    if (bus.in_data == 8'd0 || {1'b0, bus.in_data} > MAX_N) begin
                        w_state_next = S_ERROR; w_err_next = ERR_BAD_COUNT; w_err_we = 1'b1;
                    end else begin
                        w_state_next = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_expired) begin
                    w_state_next = S_ERROR; w_err_next = ERR_TIMEOUT; w_err_we = 1'b1;
                end else if (w_hs) begin
                    if ((bus.in_data & ~HI_MASK) != 8'd0) begin
                        w_state_next = S_ERROR; w_err_next = ERR_BAD_CHK; w_err_we = 1'b1;
                    end else begin
                        w_state_next = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_expired) begin
                    w_state_next = S_ERROR; w_err_next = ERR_TIMEOUT; w_err_we = 1'b1;
                end else if (w_hs) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: w_state_next = w_last ? S_CHECK : S_HI;
            S_CHECK: begin
                if (w_expired) begin
                    w_state_next = S_ERROR; w_err_next = ERR_TIMEOUT; w_err_we = 1'b1;
                end else if (w_hs) begin
                    if (bus.in_data == r_chk) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ERROR; w_err_next = ERR_BAD_CHK; w_err_we = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: word assembly, running checksum and write counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err          <= ERR_NONE;
            r_n            <= '0;
            r_words_loaded <= '0;
            r_chk          <= '0;
            r_word         <= '0;
        end else begin
            if (w_err_we) r_err <= w_err_next;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_sync) begin
                        r_words_loaded <= '0;
                        r_chk          <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_hs) begin
                        r_n   <= NW'(bus.in_data);
                        r_chk <= bus.in_data;
                    end
                end
                S_HI: begin
                    if (w_hs) begin
                        r_word[DATA_W-1:8] <= bus.in_data[DATA_W-9:0];
                        r_chk              <= r_chk ^ bus.in_data;
                    end
                end
                S_LO: begin
                    if (w_hs) begin
                        r_word[7:0] <= bus.in_data;
                        r_chk       <= r_chk ^ bus.in_data;
                    end
                end
                S_WRITE: r_words_loaded <= r_words_loaded + NW'(1);
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state != S_WRITE);
    assign bus.mem_we     = (r_state == S_WRITE);
    assign bus.mem_addr   = r_words_loaded[ADDR_W-1:0];
    assign bus.mem_wdata  = r_word;
    assign o_cpu_hold     = !((r_state == S_IDLE) || (r_state == S_DONE));
    assign o_done         = (r_state == S_DONE);
    assign o_error        = (r_state == S_ERROR);
    assign o_err_code     = r_err;
    assign o_words_loaded = r_words_loaded;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench: frame-level reference model predicts memory writes and final status.
module tb_program_loader;
    localparam int AW = 6;
    localparam int DW = 12;
    localparam int TO = 20;

    typedef logic [7:0]  bq_t[$];
    typedef logic [11:0] wq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_hold, done, error;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    program_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .bus            (bus),
        .o_cpu_hold     (cpu_hold),
        .o_done         (done),
        .o_error        (error),
        .o_err_code     (err_code),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          stalls = 0;
    logic [17:0] exp_wr[$];
    int          m_err, m_words, m_len;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Builds a well-formed frame; chk_xor != 0 corrupts the checksum byte.
    function automatic bq_t mkf(input wq_t w, input logic [7:0] chk_xor);
        bq_t         f;
        logic [7:0]  c, hi, lo;
        c = 8'(w.size());
        f.push_back(8'hA5);
        f.push_back(c);
        foreach (w[i]) begin
            hi = {4'b0, w[i][11:8]};
            lo = w[i][7:0];
            c  = c ^ hi ^ lo;
            f.push_back(hi);
            f.push_back(lo);
        end
        f.push_back(c ^ chk_xor);
        return f;
    endfunction

    // Reference: walk the frame, queue the writes it implies, decide outcome and bytes consumed.
    task automatic model(input bq_t f);
        int n;
        logic [7:0] c, hi, lo;
        m_err = 0; m_words = 0; m_len = f.size();
        if (f.size() < 2) begin m_err = 3; return; end
        n = int'(f[1]);
        if (n == 0 || n > 2 ** AW) begin m_err = 1; m_len = 2; return; end
        c = f[1];
        for (int i = 0; i < n; i++) begin
            if (2 + 2 * i >= f.size()) begin m_err = 3; return; end
            hi = f[2 + 2 * i];
            if (hi > 8'h0F) begin m_err = 2; m_len = 3 + 2 * i; return; end
            if (3 + 2 * i >= f.size()) begin m_err = 3; return; end
            lo = f[3 + 2 * i];
            c  = c ^ hi ^ lo;
            exp_wr.push_back({6'(i), hi[3:0], lo});
            m_words++;
        end
        if (2 + 2 * n >= f.size()) begin m_err = 3; return; end
        m_len = 3 + 2 * n;
        m_err = (f[2 + 2 * n] == c) ? 0 : 2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 8) begin
            @(negedge clk);
            k++;
            stalls++;
        end
        if (k >= 8) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input bq_t f, input int gmax);
        model(f);
        for (int i = 0; i < m_len; i++) begin
            if (gmax > 0) idle($urandom_range(0, gmax));
            send_byte(f[i]);
            if (i == 0) check("hold_rise", 32'(cpu_hold), 32'd1);
        end
        idle((m_err == 3) ? TO + 4 : 1);
        check("done",         32'(done),         32'(m_err == 0));
        check("error",        32'(error),        32'(m_err != 0));
        check("err_code",     32'(err_code),     32'(m_err));
        check("words_loaded", 32'(words_loaded), 32'(m_words));
        check("cpu_hold",     32'(cpu_hold),     32'(m_err != 0));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_cpu_hold",  32'(cpu_hold),      32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_error",     32'(error),         32'd0);
        check("rst_err_code",  32'(err_code),      32'd0);
        check("rst_words",     32'(words_loaded),  32'd0);
    endtask

    initial begin
        wq_t        w;
        bq_t        f;
        logic [17:0] e;
        int         n, kind;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", 32'(bus.mem_we), 32'd0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(e));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        idle(2);

        w = '{12'hABC};
        run_frame(mkf(w, 8'h00), 0);

        w = {};
        for (int i = 0; i < 64; i++) w.push_back(12'(i * 3));
        run_frame(mkf(w, 8'h00), 1);

        run_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h00}, 0);
        run_frame('{8'hA5, 8'h00}, 0);
        run_frame('{8'hA5, 8'h41}, 0);
        run_frame('{8'hA5, 8'h01, 8'h1F}, 0);
        run_frame('{8'hA5, 8'h01, 8'h0A}, 0);

        w = '{12'h123, 12'h0A5, 12'hFFF};
        run_frame(mkf(w, 8'h00), 2);

        // Reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        idle(2);

        // Back-to-back bytes: exactly one stall per word
        w = {};
        n = $urandom_range(2, 20);
        for (int i = 0; i < n; i++) w.push_back(12'($urandom));
        stalls = 0;
        run_frame(mkf(w, 8'h00), 0);
        check("stalls_per_word", 32'(stalls), 32'(n));

        for (int r = 0; r < 14; r++) begin
            w = {};
            n = (r % 3 == 0) ? $urandom_range(1, 4) : $urandom_range(1, 64);
            for (int i = 0; i < n; i++) w.push_back(12'($urandom));
            kind = $urandom_range(0, 5);
            f = mkf(w, (kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00);
            if (kind == 4) begin
                int j;
                j = $urandom_range(0, n - 1);
                f[2 + 2 * j] = f[2 + 2 * j] | (8'h10 << $urandom_range(0, 3));
            end
            if (kind == 5) begin
                int k;
                k = $urandom_range(1, f.size() - 1);
                while (f.size() > k) void'(f.pop_back());
            end
            run_frame(f, $urandom_range(0, 3));
        end

        idle(4);
        check("exp_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
